// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: one data-SRAM access per instruction over a req/addr_ok/data_ok port,
// with B/H/W sizing, load extension, misalignment detection, ID forwarding and flush draining.
module mem_stage_lsu #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exe_to_mem_valid,
    output logic              mem_allow_in,
    input  logic              wb_allow_in,
    output logic              mem_to_wb_valid,
    input  logic              flush,
    input  logic [31:0]       exe_pc,
    input  logic [ADDR_W-1:0] exe_alu_result,
    input  logic [DATA_W-1:0] exe_rkd_value,
    input  logic [4:0]        exe_mem_op,
    input  logic              exe_reg_we,
    input  logic [RA_W-1:0]   exe_reg_waddr,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [31:0]       wb_pc,
    output logic [DATA_W-1:0] wb_result,
    output logic              wb_reg_we,
    output logic [RA_W-1:0]   wb_reg_waddr,
    output logic              wb_ale,
    output logic              fwd_valid,
    output logic              fwd_reg_we,
    output logic [RA_W-1:0]   fwd_waddr,
    output logic [DATA_W-1:0] fwd_result,
    output logic              fwd_pending
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_mem_valid;
    logic [31:0]         r_pc;
    logic [ADDR_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_rkd;
    logic [4:0]          r_op;
    logic                r_reg_we;
    logic [RA_W-1:0]     r_waddr;
    logic                r_ale;
    logic [DATA_W-1:0]   r_load_data;

    logic                w_mem_en;
    logic                w_store;
    logic                w_load;
    logic                w_ready_go;
    logic                w_handoff;
    logic                w_capture;
    logic                w_in_ale;
    logic                w_in_go_mem;
    logic [DATA_W-1:0]   w_ext;

    // Align the addressed byte/half to bit 0, then sign- or zero-extend.
    function automatic logic [DATA_W-1:0] load_ext(
        input logic [DATA_W-1:0] rd,
        input logic [1:0]        off,
        input logic [1:0]        sz,
        input logic              uns
    );
        logic [DATA_W-1:0] sh;
        sh = rd >> {off, 3'b000};
        case (sz)
            2'b00:   return uns ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                                : {{(DATA_W-8){sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                                : {{(DATA_W-16){sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign w_mem_en    = r_op[3];
    assign w_store     = r_op[2];
    assign w_load      = w_mem_en && !w_store;
    assign w_ready_go  = !w_mem_en || r_ale || (r_state == S_DONE)
                       || ((r_state == S_WAIT) && data_data_ok);
    assign w_handoff   = r_mem_valid && w_ready_go && wb_allow_in && !flush;

    // A drain in progress blocks intake so the stale response cannot be taken as a new one.
    assign mem_allow_in    = (r_state != S_DRAIN) && (!r_mem_valid || (w_ready_go && wb_allow_in));
    assign w_capture       = mem_allow_in && exe_to_mem_valid && !flush;
    assign mem_to_wb_valid = r_mem_valid && w_ready_go && !flush;

    assign w_in_ale    = exe_mem_op[3]
                       && (((exe_mem_op[1:0] == 2'b01) && exe_alu_result[0])
                        || ((exe_mem_op[1:0] == 2'b10) && (exe_alu_result[1:0] != 2'b00)));
    assign w_in_go_mem = exe_mem_op[3] && !w_in_ale;

    assign w_ext = load_ext(data_rdata, r_alu[1:0], r_op[1:0], r_op[4]);

    // Stage valid and access FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
        end else begin
            if (flush) begin
                r_mem_valid <= 1'b0;
            end else if (w_capture) begin
                r_mem_valid <= 1'b1;
            end else if (w_handoff) begin
                r_mem_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_capture && w_in_go_mem) r_state <= S_REQ;
                end
                S_REQ: begin
                    if (flush) begin
                        r_state <= data_addr_ok ? S_DRAIN : S_IDLE;
                    end else if (data_addr_ok) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        r_state <= data_data_ok ? S_IDLE : S_DRAIN;
                    end else if (data_data_ok) begin
                        if (!wb_allow_in)                    r_state <= S_DONE;
                        else if (w_capture && w_in_go_mem)   r_state <= S_REQ;
                        else                                 r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (wb_allow_in) begin
                        r_state <= (w_capture && w_in_go_mem) ? S_REQ : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (data_data_ok) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage payload and held load data; contents are qualified by r_mem_valid.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_pc     <= exe_pc;
            r_alu    <= exe_alu_result;
            r_rkd    <= exe_rkd_value;
            r_op     <= exe_mem_op;
            r_reg_we <= exe_reg_we;
            r_waddr  <= exe_reg_waddr;
            r_ale    <= w_in_ale;
        end
        if ((r_state == S_WAIT) && data_data_ok) begin
            r_load_data <= w_ext;
        end
    end

    assign data_req   = (r_state == S_REQ);
    assign data_wr    = w_store;
    assign data_size  = r_op[1:0];
    assign data_addr  = r_alu;

    always_comb begin
        data_wstrb = 4'b0000;
        data_wdata = r_rkd;
        case (r_op[1:0])
            2'b00: begin
                data_wstrb = 4'b0001 << r_alu[1:0];
                data_wdata = {4{r_rkd[7:0]}};
            end
            2'b01: begin
                data_wstrb = 4'b0011 << r_alu[1:0];
                data_wdata = {2{r_rkd[15:0]}};
            end
            default: begin
                data_wstrb = 4'b1111;
                data_wdata = r_rkd;
            end
        endcase
        if (!w_store) data_wstrb = 4'b0000;
    end

    // Same-cycle response is passed straight through; once in DONE the held copy is used.
    assign wb_result    = (w_load && !r_ale)
                        ? ((r_state == S_DONE) ? r_load_data : w_ext)
                        : DATA_W'(r_alu);
    assign wb_pc        = r_pc;
    assign wb_reg_we    = r_mem_valid && r_reg_we && !r_ale && !(w_mem_en && w_store);
    assign wb_reg_waddr = r_waddr;
    assign wb_ale       = r_mem_valid && r_ale;

    assign fwd_valid    = r_mem_valid;
    assign fwd_reg_we   = wb_reg_we;
    assign fwd_waddr    = r_waddr;
    assign fwd_result   = wb_result;
    assign fwd_pending  = r_mem_valid && w_load && !r_ale && !w_ready_go;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stimulus pushes expected WB records, a monitor pops and
// compares them on every MEM->WB hand-off.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_to_mem_valid;
    logic        mem_allow_in;
    logic        wb_allow_in;
    logic        mem_to_wb_valid;
    logic        flush;
    logic [31:0] exe_pc;
    logic [31:0] exe_alu_result;
    logic [31:0] exe_rkd_value;
    logic [4:0]  exe_mem_op;
    logic        exe_reg_we;
    logic [4:0]  exe_reg_waddr;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] wb_pc;
    logic [31:0] wb_result;
    logic        wb_reg_we;
    logic [4:0]  wb_reg_waddr;
    logic        wb_ale;
    logic        fwd_valid;
    logic        fwd_reg_we;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_result;
    logic        fwd_pending;

    mem_stage_lsu #(.ADDR_W(32), .DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .reset(reset),
        .exe_to_mem_valid(exe_to_mem_valid), .mem_allow_in(mem_allow_in),
        .wb_allow_in(wb_allow_in), .mem_to_wb_valid(mem_to_wb_valid), .flush(flush),
        .exe_pc(exe_pc), .exe_alu_result(exe_alu_result), .exe_rkd_value(exe_rkd_value),
        .exe_mem_op(exe_mem_op), .exe_reg_we(exe_reg_we), .exe_reg_waddr(exe_reg_waddr),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wb_pc(wb_pc), .wb_result(wb_result), .wb_reg_we(wb_reg_we),
        .wb_reg_waddr(wb_reg_waddr), .wb_ale(wb_ale),
        .fwd_valid(fwd_valid), .fwd_reg_we(fwd_reg_we), .fwd_waddr(fwd_waddr),
        .fwd_result(fwd_result), .fwd_pending(fwd_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic        we;
        logic [4:0]  wa;
        logic        ale;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [4:0] OP_LDW  = 5'b01010;
    localparam logic [4:0] OP_LDB  = 5'b01000;
    localparam logic [4:0] OP_LDBU = 5'b11000;
    localparam logic [4:0] OP_LDH  = 5'b01001;
    localparam logic [4:0] OP_LDHU = 5'b11001;
    localparam logic [4:0] OP_STB  = 5'b01100;
    localparam logic [4:0] OP_STH  = 5'b01101;
    localparam logic [4:0] OP_STW  = 5'b01110;
    localparam logic [4:0] OP_ALU  = 5'b00000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [31:0] pc, input logic [31:0] res, input logic we,
                             input logic [4:0] wa, input logic ale);
        exp_t e;
        e.pc = pc; e.res = res; e.we = we; e.wa = wa; e.ale = ale;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and hold it until MEM captures it; returns in the cycle after capture.
    task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rkd,
                        input logic [4:0] op, input logic we, input logic [4:0] wa);
        int n;
        exe_pc = pc; exe_alu_result = alu; exe_rkd_value = rkd;
        exe_mem_op = op; exe_reg_we = we; exe_reg_waddr = wa;
        exe_to_mem_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mem_allow_in && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'd1, 32'd0);
        step();
        exe_to_mem_valid = 1'b0;
    endtask

    // Memory side: addr_ok after aw idle cycles, data_ok dw cycles after that; counts pending cycles.
    task automatic mem_xact(input int aw, input int dw, input logic [31:0] rd, output int pend);
        pend = 0;
        for (int i = 0; i < aw; i++) begin
            @(negedge clk);
            if (fwd_pending) pend++;
            step();
        end
        data_addr_ok = 1'b1;
        @(negedge clk);
        if (fwd_pending) pend++;
        chk("req_at_addr_ok", 32'(data_req), 32'd1);
        step();
        data_addr_ok = 1'b0;
        for (int i = 0; i < dw; i++) begin
            @(negedge clk);
            if (fwd_pending) pend++;
            step();
        end
        data_data_ok = 1'b1;
        data_rdata   = rd;
        @(negedge clk);
        if (fwd_pending) pend++;
        step();
        data_data_ok = 1'b0;
    endtask

    // Scoreboard monitor: every hand-off must match the oldest expected record.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && mem_to_wb_valid && wb_allow_in) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_handoff: got pc %h expected none", wb_pc);
                end else begin
                    e = q.pop_front();
                    chk("wb_pc", wb_pc, e.pc);
                    chk("wb_result", wb_result, e.res);
                    chk("wb_reg_we", 32'(wb_reg_we), 32'(e.we));
                    chk("wb_reg_waddr", 32'(wb_reg_waddr), 32'(e.wa));
                    chk("wb_ale", 32'(wb_ale), 32'(e.ale));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int pend;
        reset = 1'b1; exe_to_mem_valid = 1'b0; wb_allow_in = 1'b1; flush = 1'b0;
        exe_pc = '0; exe_alu_result = '0; exe_rkd_value = '0; exe_mem_op = '0;
        exe_reg_we = 1'b0; exe_reg_waddr = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_to_wb_valid", 32'(mem_to_wb_valid), 32'd0);
        chk("rst_data_req", 32'(data_req), 32'd0);
        chk("rst_wb_reg_we", 32'(wb_reg_we), 32'd0);
        chk("rst_wb_ale", 32'(wb_ale), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_mem_allow_in", 32'(mem_allow_in), 32'd1);
        step();

        // LD.W, addr_ok in cycle 1, data_ok in cycle 3
        expect_wb(32'h1000_0000, 32'h8001_0203, 1'b1, 5'd3, 1'b0);
        send(32'h1000_0000, 32'h0000_0100, 32'h0, OP_LDW, 1'b1, 5'd3);
        mem_xact(0, 1, 32'h8001_0203, pend);
        chk("ldw_pending_cycles", 32'(pend), 32'd2);

        // Byte/half loads with sign and zero extension
        expect_wb(32'h1000_0004, 32'hFFFF_FF80, 1'b1, 5'd4, 1'b0);
        send(32'h1000_0004, 32'h0000_0103, 32'h0, OP_LDB, 1'b1, 5'd4);
        mem_xact(0, 0, 32'h80FF_0000, pend);
        expect_wb(32'h1000_0008, 32'h0000_0080, 1'b1, 5'd5, 1'b0);
        send(32'h1000_0008, 32'h0000_0103, 32'h0, OP_LDBU, 1'b1, 5'd5);
        mem_xact(1, 0, 32'h80FF_0000, pend);
        expect_wb(32'h1000_000C, 32'hFFFF_80FF, 1'b1, 5'd6, 1'b0);
        send(32'h1000_000C, 32'h0000_0102, 32'h0, OP_LDH, 1'b1, 5'd6);
        mem_xact(0, 2, 32'h80FF_0000, pend);

        // ST.H at 0x106
        expect_wb(32'h1000_0010, 32'h0000_0106, 1'b0, 5'd7, 1'b0);
        send(32'h1000_0010, 32'h0000_0106, 32'h1234_ABCD, OP_STH, 1'b1, 5'd7);
        chk("sth_wstrb", 32'(data_wstrb), 32'h0000_000C);
        chk("sth_wdata", data_wdata, 32'hABCD_ABCD);
        chk("sth_wr", 32'(data_wr), 32'd1);
        chk("sth_addr", data_addr, 32'h0000_0106);
        mem_xact(0, 0, 32'h0, pend);

        // ST.B at 0x101 and ST.W at 0x200
        expect_wb(32'h1000_0014, 32'h0000_0101, 1'b0, 5'd8, 1'b0);
        send(32'h1000_0014, 32'h0000_0101, 32'h5566_77EF, OP_STB, 1'b1, 5'd8);
        chk("stb_wstrb", 32'(data_wstrb), 32'h0000_0002);
        chk("stb_wdata", data_wdata, 32'hEFEF_EFEF);
        mem_xact(0, 0, 32'h0, pend);
        expect_wb(32'h1000_0018, 32'h0000_0200, 1'b0, 5'd9, 1'b0);
        send(32'h1000_0018, 32'h0000_0200, 32'h8765_4321, OP_STW, 1'b1, 5'd9);
        chk("stw_wstrb", 32'(data_wstrb), 32'h0000_000F);
        chk("stw_wdata", data_wdata, 32'h8765_4321);
        mem_xact(0, 0, 32'h0, pend);

        // Misaligned LD.W and LD.H: no request, ale set, valid right away
        expect_wb(32'h1000_001C, 32'h0000_0101, 1'b0, 5'd10, 1'b1);
        send(32'h1000_001C, 32'h0000_0101, 32'h0, OP_LDW, 1'b1, 5'd10);
        chk("ale_w_no_req", 32'(data_req), 32'd0);
        chk("ale_w_valid", 32'(mem_to_wb_valid), 32'd1);
        step();
        chk("ale_w_no_req_after", 32'(data_req), 32'd0);
        expect_wb(32'h1000_0020, 32'h0000_0103, 1'b0, 5'd11, 1'b1);
        send(32'h1000_0020, 32'h0000_0103, 32'h0, OP_LDH, 1'b1, 5'd11);
        chk("ale_h_no_req", 32'(data_req), 32'd0);
        step();

        // Non-memory op passes the ALU result
        expect_wb(32'h1000_0024, 32'hDEAD_BEEF, 1'b1, 5'd12, 1'b0);
        send(32'h1000_0024, 32'hDEAD_BEEF, 32'h0, OP_ALU, 1'b1, 5'd12);
        chk("alu_no_req", 32'(data_req), 32'd0);
        step();

        // Flush in WAIT: stale data_ok swallowed, next load gets its own data
        send(32'h1000_0028, 32'h0000_0300, 32'h0, OP_LDW, 1'b1, 5'd13);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_no_handoff", 32'(mem_to_wb_valid), 32'd0);
        step();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drain_fwd_valid", 32'(fwd_valid), 32'd0);
            chk("drain_allow_in", 32'(mem_allow_in), 32'd0);
            step();
        end
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("drain_allow_in_dok", 32'(mem_allow_in), 32'd0);
        step();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("after_drain_allow_in", 32'(mem_allow_in), 32'd1);
        step();
        expect_wb(32'h1000_002C, 32'h1122_3344, 1'b1, 5'd14, 1'b0);
        send(32'h1000_002C, 32'h0000_0304, 32'h0, OP_LDW, 1'b1, 5'd14);
        mem_xact(0, 0, 32'h1122_3344, pend);

        // WB back-pressure for 3 cycles after data_ok
        wb_allow_in = 1'b0;
        expect_wb(32'h1000_0030, 32'hCAFE_F00D, 1'b1, 5'd15, 1'b0);
        send(32'h1000_0030, 32'h0000_0400, 32'h0, OP_LDW, 1'b1, 5'd15);
        mem_xact(0, 0, 32'hCAFE_F00D, pend);
        data_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(mem_to_wb_valid), 32'd1);
            chk("bp_result", wb_result, 32'hCAFE_F00D);
            chk("bp_allow_in", 32'(mem_allow_in), 32'd0);
            chk("bp_no_req", 32'(data_req), 32'd0);
            step();
        end
        wb_allow_in = 1'b1;
        step();

        // Back-to-back loads: hand-off and capture in the same cycle
        expect_wb(32'h1000_0034, 32'h0A0B_0C0D, 1'b1, 5'd16, 1'b0);
        expect_wb(32'h1000_0038, 32'h0000_F00D, 1'b1, 5'd17, 1'b0);
        send(32'h1000_0034, 32'h0000_0500, 32'h0, OP_LDW, 1'b1, 5'd16);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0A0B_0C0D;
        exe_pc = 32'h1000_0038; exe_alu_result = 32'h0000_0506; exe_rkd_value = 32'h0;
        exe_mem_op = OP_LDHU; exe_reg_we = 1'b1; exe_reg_waddr = 5'd17;
        exe_to_mem_valid = 1'b1;
        @(negedge clk);
        chk("b2b_allow_in", 32'(mem_allow_in), 32'd1);
        step();
        data_data_ok = 1'b0;
        exe_to_mem_valid = 1'b0;
        chk("b2b_req", 32'(data_req), 32'd1);
        chk("b2b_addr", data_addr, 32'h0000_0506);
        mem_xact(0, 0, 32'hF00D_1234, pend);

        repeat (3) step();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
